alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter ALU_LAT, default 1, legal 1..15, giving the clocks from alu_* inputs stable to alu_sum valid.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port req_opcode  input  4  ALU operation code, passed through unmodified.
REQ-008 The block SHALL have ports req_a, req_b  input  WIDTH  operands.
REQ-009 The block SHALL have port req_carry_in  input  1  explicit carry for this request.
REQ-010 The block SHALL have port req_chain  input  1  1 = use stored carry_flag instead of req_carry_in.
REQ-011 The block SHALL have ports alu_opcode (4), alu_a, alu_b (WIDTH), alu_carry_in (1), all outputs, registered, driving the ALU.
REQ-012 The block SHALL have ports alu_sum  input  WIDTH, and alu_carry_out  input  1, the ALU results.
REQ-013 The block SHALL have port rsp_valid  output  1  result present.
REQ-014 The block SHALL have port rsp_ready  input  1  consumer takes result.
REQ-015 The block SHALL have ports rsp_sum  output  WIDTH, rsp_carry  output  1, rsp_zero  output  1 (rsp_sum == 0).
REQ-016 The block SHALL have port carry_flag  output  1  carry stored from the last captured result.

Function
REQ-017 The block SHALL implement the FSM states IDLE, WAIT and DONE, with one request in flight at most.
REQ-018 In IDLE, req_ready SHALL be 1; in WAIT, DONE and while rst=1, req_ready SHALL be 0.
REQ-019 On an edge with req_valid=1 and req_ready=1 (edge E0), the block SHALL register alu_opcode, alu_a, alu_b and alu_carry_in, and SHALL go to WAIT with latency counter = ALU_LAT-1.
REQ-020 alu_carry_in SHALL be registered as carry_flag when req_chain=1, else as req_carry_in.
REQ-021 In WAIT, on each edge, the block SHALL capture alu_sum and alu_carry_out into rsp_sum and rsp_carry if the counter is 0, then go to DONE; otherwise it SHALL decrement the counter.
REQ-022 Capture SHALL occur on edge E0+ALU_LAT exactly, and rsp_valid SHALL be 1 from that edge onward.
REQ-023 carry_flag SHALL update to alu_carry_out on the capture edge only.
REQ-024 rsp_zero SHALL be registered at capture as (alu_sum == 0) over all WIDTH bits.
REQ-025 In DONE, rsp_valid SHALL be 1, and rsp_sum, rsp_carry and rsp_zero SHALL be held stable until an edge with rsp_ready=1.
REQ-026 On that rsp_ready edge, the block SHALL go to IDLE with rsp_valid=0; rsp_sum, rsp_carry and rsp_zero SHALL retain their values.
REQ-027 alu_* outputs SHALL hold their values from acceptance until the next acceptance.
REQ-028 req_valid SHALL be ignored outside IDLE, and no request SHALL be accepted in the same cycle a response is consumed.
REQ-029 Minimum request spacing SHALL be ALU_LAT+2 cycles, with rsp_ready tied to 1.
REQ-030 rsp_ready asserted outside DONE SHALL have no effect.

Reset
REQ-031 An edge with rst=1 SHALL force state to IDLE, counter to 0, and carry_flag, rsp_valid, rsp_sum, rsp_carry, rsp_zero, alu_opcode, alu_a, alu_b and alu_carry_in to 0.
REQ-032 rst SHALL take priority over every other input on the same edge.
REQ-033 An rst edge in WAIT or DONE SHALL abandon the operation, and no response SHALL be produced for it.
REQ-034 req_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-035 Bench SHALL cover: ALU_LAT=1, model returns a*b for opcode 3, request opcode=3 a=5 b=10 -> alu_* valid after E0, rsp_valid at E0+1 with rsp_sum=50, rsp_carry=0, rsp_zero=0.
REQ-036 Bench SHALL cover: ALU_LAT=3, model add, a=0xFF b=0x01 carry_in=0 -> rsp_valid first at E0+3 (not earlier), rsp_sum=0x00, rsp_carry=1, rsp_zero=1, carry_flag=1.
REQ-037 Bench SHALL cover: following that, a request with req_chain=1, req_carry_in=0, a=0x00 b=0x00 -> alu_carry_in=1, rsp_sum=0x01, carry_flag=0.
REQ-038 Bench SHALL cover: rsp_ready held 0 for 5 cycles in DONE with req_valid=1 throughout -> rsp_* stable, req_ready=0, no acceptance; first acceptance on the edge after the rsp_ready edge.
REQ-039 Bench SHALL cover: rst pulsed for 1 cycle during WAIT (ALU_LAT=3) -> rsp_valid never rises for that request, all outputs 0, req_ready=1 on the next cycle.

Source files
------------

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - single-outstanding request dispatcher for a fixed-latency external ALU

module alu_dispatch #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_opcode,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_carry_in,
    input  logic             req_chain,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_carry_in,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_carry_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic             carry_flag
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Counter preload: capture lands exactly ALU_LAT edges after acceptance.
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0] state;
    logic [3:0] cnt;

    assign req_ready = (state == S_IDLE) && !rst;
    assign rsp_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= 4'd0;
            carry_flag   <= 1'b0;
            rsp_sum      <= '0;
            rsp_carry    <= 1'b0;
            rsp_zero     <= 1'b0;
            alu_opcode   <= 4'd0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_carry_in <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        alu_opcode   <= req_opcode;
                        alu_a        <= req_a;
                        alu_b        <= req_b;
                        alu_carry_in <= req_chain ? carry_flag : req_carry_in;
                        cnt          <= LAT_M1;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        rsp_sum    <= alu_sum;
                        rsp_carry  <= alu_carry_out;
                        rsp_zero   <= (alu_sum == '0);
                        carry_flag <= alu_carry_out;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    // Consuming edge never doubles as an accept edge; IDLE comes first.
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// tb/tb_alu_dispatch.sv - self-checking bench for alu_dispatch at ALU_LAT=1 (dut 0) and ALU_LAT=3 (dut 1)

module tb_alu_dispatch;

    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst          [2];
    logic         req_valid    [2];
    logic         req_ready    [2];
    logic [3:0]   req_opcode   [2];
    logic [W-1:0] req_a        [2];
    logic [W-1:0] req_b        [2];
    logic         req_carry_in [2];
    logic         req_chain    [2];
    logic [3:0]   alu_opcode   [2];
    logic [W-1:0] alu_a        [2];
    logic [W-1:0] alu_b        [2];
    logic         alu_carry_in [2];
    logic         rsp_valid    [2];
    logic         rsp_ready    [2];
    logic [W-1:0] rsp_sum      [2];
    logic         rsp_carry    [2];
    logic         rsp_zero     [2];
    logic         carry_flag   [2];

    int n_vec = 0;
    int n_err = 0;
    logic exp_flag [2];
    int lat_of [2] = '{1, 3};

    // Reference ALU: {carry, sum}
    function automatic logic [W:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        logic [2*W-1:0] p;
        case (op)
            4'd1: return {1'b0, a & b};
            4'd2: return {cin, a ^ b};
            4'd3: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return {|p[2*W-1:W], p[W-1:0]};
            end
            default: return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [2*W+4:0] vec;
        logic [2*W+4:0] hist [0:3];
        logic           stable;
        logic [W:0]     r;
        logic [W-1:0]   alu_sum;
        logic           alu_carry_out;

        assign vec = {alu_opcode[g], alu_a[g], alu_b[g], alu_carry_in[g]};

        always @(posedge clk) begin
            hist[0] <= vec;
            for (int i = 1; i < 4; i++) hist[i] <= hist[i-1];
        end

        // ALU result is only trustworthy once its inputs have been stable LAT cycles; before that it is inverted.
        always_comb begin
            stable = 1'b1;
            for (int i = 0; i < LAT - 1; i++) if (hist[i] !== vec) stable = 1'b0;
            r = alu_ref(alu_opcode[g], alu_a[g], alu_b[g], alu_carry_in[g]);
            alu_sum       = stable ? r[W-1:0] : ~r[W-1:0];
            alu_carry_out = stable ? r[W] : ~r[W];
        end

        alu_dispatch #(.WIDTH(W), .ALU_LAT(LAT)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_opcode   (req_opcode[g]),
            .req_a        (req_a[g]),
            .req_b        (req_b[g]),
            .req_carry_in (req_carry_in[g]),
            .req_chain    (req_chain[g]),
            .alu_opcode   (alu_opcode[g]),
            .alu_a        (alu_a[g]),
            .alu_b        (alu_b[g]),
            .alu_carry_in (alu_carry_in[g]),
            .alu_sum      (alu_sum),
            .alu_carry_out(alu_carry_out),
            .rsp_valid    (rsp_valid[g]),
            .rsp_ready    (rsp_ready[g]),
            .rsp_sum      (rsp_sum[g]),
            .rsp_carry    (rsp_carry[g]),
            .rsp_zero     (rsp_zero[g]),
            .carry_flag   (carry_flag[g])
        );
    end

    // Called at a negedge; returns after the accept edge, at the following negedge.
    task automatic issue(input int d, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic chain, output logic [W:0] exp);
        logic eff;
        n_vec++;
        if (req_ready[d] !== 1'b1) begin
            n_err++; $display("FAIL issue_ready d=%0d got %b expected 1", d, req_ready[d]);
        end
        req_valid[d] = 1'b1; req_opcode[d] = op; req_a[d] = a; req_b[d] = b;
        req_carry_in[d] = cin; req_chain[d] = chain;
        eff = chain ? exp_flag[d] : cin;
        exp = alu_ref(op, a, b, eff);
        @(negedge clk);
        req_valid[d] = 1'b0;
        n_vec++;
        if ({alu_opcode[d], alu_a[d], alu_b[d], alu_carry_in[d]} !== {op, a, b, eff}) begin
            n_err++; $display("FAIL alu_regs d=%0d got %h/%h/%h/%b expected %h/%h/%h/%b", d, alu_opcode[d],
                              alu_a[d], alu_b[d], alu_carry_in[d], op, a, b, eff);
        end
        n_vec++;
        if (req_ready[d] !== 1'b0 || rsp_valid[d] !== 1'b0) begin
            n_err++; $display("FAIL after_accept d=%0d got ready=%b valid=%b expected 0/0", d, req_ready[d],
                              rsp_valid[d]);
        end
    endtask

    task automatic await_capture(input int d, input logic [W:0] exp);
        for (int k = 1; k < lat_of[d]; k++) begin
            rsp_ready[d] = 1'($urandom);
            @(negedge clk);
            n_vec++;
            if (rsp_valid[d] !== 1'b0) begin
                n_err++; $display("FAIL early_rsp d=%0d edge E0+%0d got rsp_valid=%b expected 0", d, k, rsp_valid[d]);
            end
        end
        rsp_ready[d] = 1'($urandom);
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        n_vec++;
        if (rsp_valid[d] !== 1'b1) begin
            n_err++; $display("FAIL capture_valid d=%0d got %b expected 1", d, rsp_valid[d]);
        end
        n_vec++;
        if ({rsp_carry[d], rsp_sum[d]} !== exp || rsp_zero[d] !== (exp[W-1:0] == '0) || carry_flag[d] !== exp[W])
        begin
            n_err++; $display("FAIL result d=%0d got c=%b s=%h z=%b f=%b expected c=%b s=%h z=%b f=%b", d,
                              rsp_carry[d], rsp_sum[d], rsp_zero[d], carry_flag[d], exp[W], exp[W-1:0],
                              exp[W-1:0] == '0, exp[W]);
        end
    endtask

    task automatic consume(input int d, input logic [W:0] exp);
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        n_vec++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
            n_err++; $display("FAIL consume d=%0d got valid=%b ready=%b expected 0/1", d, rsp_valid[d], req_ready[d]);
        end
        n_vec++;
        if ({rsp_carry[d], rsp_sum[d]} !== exp || carry_flag[d] !== exp[W]) begin
            n_err++; $display("FAIL retain d=%0d got %b%h f=%b expected %b%h", d, rsp_carry[d], rsp_sum[d],
                              carry_flag[d], exp[W], exp[W-1:0]);
        end
        exp_flag[d] = exp[W];
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b1; req_a[d] = 8'hAA; req_b[d] = 8'h55; req_opcode[d] = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({alu_opcode[d], alu_a[d], alu_b[d], alu_carry_in[d], rsp_sum[d], rsp_carry[d], rsp_zero[d],
                 rsp_valid[d], carry_flag[d], req_ready[d]} !== '0) begin
                n_err++; $display("FAIL reset_state d=%0d got alu_a=%h rsp_valid=%b ready=%b expected all 0", d,
                                  alu_a[d], rsp_valid[d], req_ready[d]);
            end
            rst[d] = 1'b0; req_valid[d] = 1'b0; exp_flag[d] = 1'b0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (req_ready[d] !== 1'b1) begin
                n_err++; $display("FAIL ready_after_reset d=%0d got %b expected 1", d, req_ready[d]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_mul_lat1;
        logic [W:0] exp;
        issue(0, 4'd3, 8'd5, 8'd10, 1'b0, 1'b0, exp);
        await_capture(0, exp);
        n_vec++;
        if (rsp_sum[0] !== 8'd50 || rsp_carry[0] !== 1'b0 || rsp_zero[0] !== 1'b0) begin
            n_err++; $display("FAIL mul_5x10 got s=%0d c=%b z=%b expected 50/0/0", rsp_sum[0], rsp_carry[0], rsp_zero[0]);
        end
        consume(0, exp);
    endtask

    task automatic test_add_chain;
        logic [W:0] exp;
        issue(1, 4'd0, 8'hFF, 8'h01, 1'b0, 1'b0, exp);
        await_capture(1, exp);
        n_vec++;
        if (rsp_sum[1] !== 8'h00 || rsp_carry[1] !== 1'b1 || rsp_zero[1] !== 1'b1 || carry_flag[1] !== 1'b1) begin
            n_err++; $display("FAIL add_ff_01 got s=%h c=%b z=%b f=%b expected 00/1/1/1", rsp_sum[1], rsp_carry[1],
                              rsp_zero[1], carry_flag[1]);
        end
        consume(1, exp);
        issue(1, 4'd0, 8'h00, 8'h00, 1'b0, 1'b1, exp);
        n_vec++;
        if (alu_carry_in[1] !== 1'b1) begin
            n_err++; $display("FAIL chain_cin got %b expected 1", alu_carry_in[1]);
        end
        await_capture(1, exp);
        n_vec++;
        if (rsp_sum[1] !== 8'h01 || carry_flag[1] !== 1'b0) begin
            n_err++; $display("FAIL chain_sum got s=%h f=%b expected 01/0", rsp_sum[1], carry_flag[1]);
        end
        consume(1, exp);
    endtask

    task automatic test_backpressure;
        logic [W:0] exp;
        logic [W:0] exp2;
        issue(1, 4'd0, 8'h12, 8'h34, 1'b1, 1'b0, exp);
        await_capture(1, exp);
        req_valid[1] = 1'b1; req_opcode[1] = 4'd3; req_a[1] = 8'd7; req_b[1] = 8'd9;
        req_carry_in[1] = 1'b0; req_chain[1] = 1'b0;
        exp2 = alu_ref(4'd3, 8'd7, 8'd9, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid[1] !== 1'b1 || {rsp_carry[1], rsp_sum[1]} !== exp || req_ready[1] !== 1'b0 ||
                alu_a[1] !== 8'h12) begin
                n_err++; $display("FAIL hold cycle %0d got v=%b s=%h rdy=%b alu_a=%h expected 1/%h/0/12", k,
                                  rsp_valid[1], rsp_sum[1], req_ready[1], alu_a[1], exp[W-1:0]);
            end
        end
        consume(1, exp);
        n_vec++;
        if (alu_a[1] !== 8'h12) begin
            n_err++; $display("FAIL no_accept_on_consume got alu_a=%h expected 12", alu_a[1]);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        n_vec++;
        if (alu_a[1] !== 8'd7 || req_ready[1] !== 1'b0) begin
            n_err++; $display("FAIL accept_after_consume got alu_a=%h rdy=%b expected 07/0", alu_a[1], req_ready[1]);
        end
        await_capture(1, exp2);
        consume(1, exp2);
    endtask

    task automatic test_reset_in_wait;
        logic [W:0] exp;
        issue(1, 4'd0, 8'hF0, 8'h33, 1'b1, 1'b0, exp);
        rst[1] = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({alu_opcode[1], alu_a[1], alu_b[1], alu_carry_in[1], rsp_sum[1], rsp_carry[1], rsp_zero[1],
             rsp_valid[1], carry_flag[1], req_ready[1]} !== '0) begin
            n_err++; $display("FAIL wait_reset got alu_a=%h v=%b f=%b rdy=%b expected all 0", alu_a[1], rsp_valid[1],
                              carry_flag[1], req_ready[1]);
        end
        rst[1] = 1'b0;
        exp_flag[1] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b1) begin
                n_err++; $display("FAIL abandoned cycle %0d got v=%b rdy=%b expected 0/1", k, rsp_valid[1], req_ready[1]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] exp;
        logic [W-1:0] ops [4] = '{8'hFF, 8'h00, 8'h80, 8'h7F};
        for (int i = 0; i < 4; i++) begin
            issue(0, 4'd0, ops[i], ops[i], 1'b0, 1'(i % 2), exp);
            await_capture(0, exp);
            consume(0, exp);
        end
    endtask

    task automatic test_random;
        logic [W:0] exp;
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 40; n++) begin
                issue(d, 4'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), exp);
                await_capture(d, exp);
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk);
                    n_vec++;
                    if (rsp_valid[d] !== 1'b1 || {rsp_carry[d], rsp_sum[d]} !== exp) begin
                        n_err++; $display("FAIL rand_hold d=%0d got v=%b %b%h expected 1 %b%h", d, rsp_valid[d],
                                          rsp_carry[d], rsp_sum[d], exp[W], exp[W-1:0]);
                    end
                end
                consume(d, exp);
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = 1'b0; req_opcode[d] = 4'd0; req_a[d] = '0; req_b[d] = '0;
            req_carry_in[d] = 1'b0; req_chain[d] = 1'b0; rsp_ready[d] = 1'b0; exp_flag[d] = 1'b0;
        end
        @(negedge clk);
        test_reset;
        test_mul_lat1;
        test_add_chain;
        test_backpressure;
        test_reset_in_wait;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before bench completed");
        $fatal(1);
    end

endmodule
